// File: rtl/router_pkg.sv
// Shared router definitions: packet field layout, routing target classes and
// the dx helpers used by the forwarding stages.
package router_pkg;

  localparam int PACKET_WIDTH = 30;
  localparam int DX_MSB       = 29;
  localparam int DX_LSB       = 21;
  localparam int DXW          = DX_MSB - DX_LSB + 1;

  typedef logic [PACKET_WIDTH-1:0] pkt_t;

  typedef enum logic [1:0] {
    TGT_EAST,
    TGT_TURN,
    TGT_ILLEGAL
  } target_e;

  // dx is signed two's complement: positive keeps going east, zero turns,
  // negative should never have been routed into an east stage.
  function automatic target_e classify_dx(input logic [DXW-1:0] dx);
    if (dx[DXW-1])      return TGT_ILLEGAL;
    else if (dx == '0)  return TGT_TURN;
    else                return TGT_EAST;
  endfunction

  // One hop consumed: dx-1 wraps modulo 2^DXW, every other bit untouched.
  function automatic pkt_t dec_dx(input pkt_t pkt);
    pkt_t r;
    r = pkt;
    r[DX_MSB:DX_LSB] = pkt[DX_MSB:DX_LSB] - {{(DXW-1){1'b0}}, 1'b1};
    return r;
  endfunction

endpackage

// File: rtl/forward_east_out_hold_reg.sv
// One-entry output holding register. Drains whenever the downstream FIFO has
// room and can be refilled in the same cycle it drains.
module out_hold_reg #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         full,
  output logic [W-1:0] dout,
  output logic         wen,
  output logic         can_accept
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  assign wen        = valid_q & ~full;
  assign can_accept = ~valid_q | ~full;
  assign dout       = data_q;

  // Next state: a drain empties the entry, a load (same cycle or not) refills it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (wen)  valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end
  end

  // Entry register; reset discards any held packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/forward_east.sv
// Eastward forwarding stage: arbitrates the local injection and west link
// heads onto the east neighbour and turn outputs, decrementing dx on the way
// east and dropping (and flagging) packets with negative dx.
// PACKET_WIDTH/DX_* are expected to match the router_pkg field layout.
module forward_east #(
  parameter int PACKET_WIDTH = router_pkg::PACKET_WIDTH,
  parameter int DX_MSB       = router_pkg::DX_MSB,
  parameter int DX_LSB       = router_pkg::DX_LSB
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] local_dout,
  input  logic                    local_empty,
  output logic                    local_ren,
  input  logic [PACKET_WIDTH-1:0] west_dout,
  input  logic                    west_empty,
  output logic                    west_ren,
  output logic [PACKET_WIDTH-1:0] east_dout,
  output logic                    east_wen,
  input  logic                    east_full,
  output logic [PACKET_WIDTH-1:0] turn_dout,
  output logic                    turn_wen,
  input  logic                    turn_full,
  output logic                    err_dx
);
  import router_pkg::*;

  logic    rr_q, rr_d;
  logic    err_q, err_d;
  logic    l_v, w_v;
  target_e l_tgt, w_tgt;
  logic    e_acc, t_acc;
  logic    l_ok, w_ok, contested;
  logic    l_pop, w_pop;
  logic    e_load, t_load;
  logic [PACKET_WIDTH-1:0] e_din, t_din;

  // Nothing is offered upstream while reset is held.
  assign l_v   = rst & ~local_empty;
  assign w_v   = rst & ~west_empty;
  assign l_tgt = classify_dx(local_dout[DX_MSB:DX_LSB]);
  assign w_tgt = classify_dx(west_dout[DX_MSB:DX_LSB]);

  // Arbitration, pops and output loads. Illegal heads need no output so they
  // always pop; only two legal heads aimed at the same free output contend.
  always_comb begin
    l_pop  = 1'b0;
    w_pop  = 1'b0;
    rr_d   = rr_q;
    e_load = 1'b0;
    t_load = 1'b0;
    e_din  = '0;
    t_din  = '0;

    l_ok = l_v & ((l_tgt == TGT_ILLEGAL) |
                  ((l_tgt == TGT_EAST) ? e_acc : t_acc));
    w_ok = w_v & ((w_tgt == TGT_ILLEGAL) |
                  ((w_tgt == TGT_EAST) ? e_acc : t_acc));
    contested = l_ok & w_ok & (l_tgt == w_tgt) & (l_tgt != TGT_ILLEGAL);

    if (contested) begin
      l_pop = ~rr_q;
      w_pop = rr_q;
      rr_d  = ~rr_q;          // next contest favours this cycle's loser
    end else begin
      l_pop = l_ok;
      w_pop = w_ok;
    end

    if (l_pop && l_tgt == TGT_EAST) begin
      e_load = 1'b1;
      e_din  = dec_dx(local_dout);
    end else if (w_pop && w_tgt == TGT_EAST) begin
      e_load = 1'b1;
      e_din  = dec_dx(west_dout);
    end

    if (l_pop && l_tgt == TGT_TURN) begin
      t_load = 1'b1;
      t_din  = local_dout;
    end else if (w_pop && w_tgt == TGT_TURN) begin
      t_load = 1'b1;
      t_din  = west_dout;
    end

    err_d = err_q | (l_pop & (l_tgt == TGT_ILLEGAL))
                  | (w_pop & (w_tgt == TGT_ILLEGAL));
  end

  assign local_ren = l_pop;
  assign west_ren  = w_pop;
  assign err_dx    = err_q;

  // Round-robin pointer and sticky illegal-dx flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end

  out_hold_reg #(.W(PACKET_WIDTH)) u_east (
    .clk        (clk),
    .rst_n      (rst),
    .load       (e_load),
    .din        (e_din),
    .full       (east_full),
    .dout       (east_dout),
    .wen        (east_wen),
    .can_accept (e_acc)
  );

  out_hold_reg #(.W(PACKET_WIDTH)) u_turn (
    .clk        (clk),
    .rst_n      (rst),
    .load       (t_load),
    .din        (t_din),
    .full       (turn_full),
    .dout       (turn_dout),
    .wen        (turn_wen),
    .can_accept (t_acc)
  );

endmodule

// File: doc/forward_east.md
# forward_east

Eastward forwarding stage of the per-core router. Consumes packets from the local injection FIFO (east half of the local splitter) and from the link FIFO fed by the west neighbour. Each packet with dx > 0 gets its dx field decremented and is sent to the east neighbour. Each packet with dx == 0 has finished its horizontal travel and is handed to the vertical (turn) router unchanged.

## Interface
Parameters:
- PACKET_WIDTH, 30, packet width in bits
- DX_MSB, 29, MSB of the signed two's-complement dx field
- DX_LSB, 21, LSB of the dx field (DXW = DX_MSB-DX_LSB+1)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- local_dout  in  PACKET_WIDTH  head of local FIFO; valid whenever local_empty=0 (first-word-fall-through)
- local_empty  in  1  local FIFO empty
- local_ren  out  1  pop local FIFO this cycle
- west_dout  in  PACKET_WIDTH  head of west link FIFO (FWFT)
- west_empty  in  1  west link FIFO empty
- west_ren  out  1  pop west link FIFO this cycle
- east_dout  out  PACKET_WIDTH  packet to east neighbour FIFO
- east_wen  out  1  write strobe to east FIFO
- east_full  in  1  east FIFO full
- turn_dout  out  PACKET_WIDTH  packet to vertical router FIFO
- turn_wen  out  1  write strobe to turn FIFO
- turn_full  in  1  turn FIFO full
- err_dx  out  1  sticky: a packet with dx < 0 reached this stage

## Operation
- Classify each source head: dx > 0 targets EAST; dx == 0 targets TURN; dx < 0 is ILLEGAL.
- Each output has a one-entry holding register (valid, data). Drain: wen = valid & !full. The register empties on a drain.
- Output can_accept = !valid | !full, which allows a same-cycle drain and refill.
- Per cycle each output accepts at most one packet. If the two sources target different outputs, or only one source is non-empty, every eligible source pops in the same cycle.
- If both sources target the same output and it can_accept, round-robin pointer rr chooses the winner: rr=0 favours local, rr=1 favours west.
  - After a contested grant, rr points to the loser.
  - rr is unchanged on uncontested cycles.
- EAST path: dx field replaced by dx-1, computed modulo 2^DXW over DXW bits; all other bits pass through. TURN path: packet unchanged.
- ILLEGAL head: popped unconditionally (needs no output), discarded, and err_dx set. It still takes part in arbitration, always wins, and does not move rr.
- A source is never popped unless its packet is stored or discarded in that cycle. No packet is lost or duplicated.

## Timing
- Reset (rst=0, async): holding registers invalid and data 0, rr=0, err_dx=0.
  - Reset outputs: local_ren=0, west_ren=0, east_wen=0, turn_wen=0, east_dout=0, turn_dout=0.
- local_ren, west_ren, east_wen and turn_wen are combinational from registered state and the current inputs. The doutN ports come directly from the holding registers.
- Latency: pop in cycle N -> wen asserted in cycle N+1 if the downstream FIFO is not full.
- Throughput: 1 packet/cycle per output sustained; 2 packets/cycle total when the targets differ.
- Full downstream: the holding register keeps its packet and dout stays stable until !full. The source is not popped while the register is held.
- Reset mid-operation: held packets are discarded. Upstream FIFOs are not popped while rst=0.
- err_dx clears only on reset.

## Structure
- Shared package router_pkg holds:
  - packet field constants (PACKET_WIDTH, DX_MSB/LSB);
  - a target enum {TGT_EAST, TGT_TURN, TGT_ILLEGAL};
  - function classify_dx(dx) -> target;
  - function dec_dx(pkt) -> pkt with dx-1.
- Sub-module out_hold_reg (valid/data register with can_accept/drain logic) is instantiated twice, for east and turn.

## Test plan
- Local head dx=+3, west empty, both outputs free -> local_ren in cycle 0; east_wen in cycle 1 with dx=+2 and other bits identical.
- Local dx=0 and west dx=+1 in the same cycle -> both pop in cycle 0; turn_wen (dx=0) and east_wen (dx=0) both assert in cycle 1.
- Both sources dx=+5, 4 packets each, east never full -> pops alternate L,W,L,W… after reset (rr=0 first); 8 east writes, 1 per cycle.
- east_full held high for 5 cycles with local stream dx=+2 -> one packet is held, east_dout stable, local_ren=0; after full drops, east_wen resumes next cycle with no loss.
- West head dx=-1 (0x1FF) -> popped and discarded, no wen, err_dx=1 and remains set; the next valid packet forwards normally.
- Assert rst while both holding registers are valid -> all outputs 0 immediately; after release no stale writes occur.
